// File: rtl/adc_sample_averager.sv
// Windowed averager for the serial ADC capture stage: validates 16-bit frames and
// accumulates 2^LOG2N good samples. It then offers {average, peak} on a valid/ready port.
module adc_sample_averager #(
  parameter int LOG2N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              listo,
  input  logic [3:0]        zeros,
  input  logic [11:0]       dato,
  input  logic              clr,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [11:0]       out_avg,
  output logic [11:0]       out_max,
  output logic [LOG2N:0]    cnt,
  output logic              frame_err,
  output logic              overrun
);

  localparam int N     = 1 << LOG2N;
  localparam int ACC_W = 12 + LOG2N;

  logic [ACC_W-1:0] acc;
  logic [11:0]      run_max;

  logic             good;
  logic             bad;
  logic             done;
  logic             take;
  logic [ACC_W-1:0] sum_next;
  logic [11:0]      max_next;
  logic [11:0]      avg_next;

  // NOTE: combinational helpers use blocking '=' in always_comb with every output
  // assigned first, so no latch can be inferred.
  always_comb begin
    good     = listo && (zeros == 4'b0000);
    bad      = listo && (zeros != 4'b0000);
    done     = good && (cnt == (LOG2N+1)'(N - 1));
    take     = out_valid && out_ready;
    sum_next = acc + ACC_W'(dato);
    max_next = ((cnt == '0) || (dato > run_max)) ? dato : run_max;
    // The window sum is shifted right by LOG2N. That keeps its top 12 bits.
    avg_next = sum_next[ACC_W-1:LOG2N];
  end

  // NOTE: all state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      run_max   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
      out_max   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (clr) begin
      // clr takes priority over a sample or an accept in the same cycle.
      acc       <= '0;
      run_max   <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
      out_max   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bad) begin
        frame_err <= 1'b1;
      end

      if (done) begin
        acc     <= '0;
        run_max <= '0;
        cnt     <= '0;
      end else if (good) begin
        acc     <= sum_next;
        run_max <= max_next;
        cnt     <= cnt + 1'b1;
      end

      if (done) begin
        if (!out_valid || take) begin
          out_valid <= 1'b1;
          out_avg   <= avg_next;
          out_max   <= max_next;
        end else begin
          // The held result is not accepted, so the new one is dropped.
          overrun <= 1'b1;
        end
      end else if (take) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adc_sample_averager.md
Name: adc_sample_averager

Overview:
- Downstream consumer of the serial ADC capture stage.
- Takes each 16-bit frame from the capture stage: a 4-bit zero prefix plus a 12-bit sample, qualified by a one-cycle ready strobe.
- Validates each frame, accumulates 2^LOG2N good samples, then presents the window average and window peak on a valid/ready output port to the processing logic.
- Flags frame errors and unconsumed-result overruns with sticky bits.

Parameters:
- LOG2N, 3, log2 of window length; legal 0..6; window N = 2^LOG2N samples.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- listo  input  1  sample-ready strobe from capture stage; each rising edge with listo=1 is one sample.
- zeros  input  4  frame prefix bits from capture stage; must be 4'b0000 for a good frame.
- dato  input  12  unsigned ADC sample; valid when listo=1.
- clr  input  1  synchronous clear of window, output register and flags.
- out_ready  input  1  consumer accepts result.
- out_valid  output  1  result held on out_avg/out_max.
- out_avg  output  12  floor(sum of window / N).
- out_max  output  12  largest sample in window.
- cnt  output  LOG2N+1  good samples accumulated in current window (0..N-1).
- frame_err  output  1  sticky: a frame with nonzero prefix was seen.
- overrun  output  1  sticky: a window result was discarded.

Behaviour:
- Reset (rst=1, async): accumulator=0, running max=0, cnt=0, out_valid=0, out_avg=0, out_max=0, frame_err=0, overrun=0.
- Accumulator width 12+LOG2N; it never overflows. out_avg = completed sum >> LOG2N, truncating. LOG2N=0 passes each sample through unchanged.
- Good sample (listo=1, zeros=0, clr=0):
  - acc += dato
  - max = (cnt==0) ? dato : max(max, dato)
  - cnt += 1
- Bad frame (listo=1, zeros!=0): sample discarded; acc, max and cnt unchanged; frame_err<=1.
- Window completion: the good sample taken with cnt==N-1.
  - Next edge: result = ((acc+dato)>>LOG2N, final max) is offered to the output register.
  - acc<=0, max<=0, cnt<=0.
  - Latency: one clk from the completing listo edge to out_valid.
- Output register, evaluated per edge with C = completion this cycle and T = out_valid & out_ready:
  - C & (!out_valid | T): load result; out_valid<=1.
  - C & out_valid & !T: result discarded; held outputs unchanged; overrun<=1.
  - !C & T: out_valid<=0. out_avg/out_max keep their last values.
- out_avg/out_max must be stable while out_valid=1 and not accepted.
- out_ready with out_valid=0 has no effect.
- clr=1: same effect as reset at the next edge, except synchronous. It has priority over listo and out_ready in the same cycle; that cycle's sample is dropped.
- listo high on consecutive cycles: each cycle counts as a separate sample. The block never stalls the capture stage; there is no backpressure upstream.
- dato and zeros are sampled only when listo=1; other values are ignored.
- rst asserted mid-window: the partial window is lost, and the next window starts from the first good sample after rst is released.
- Sticky flags clear only on rst or clr.

Test Plan:
- LOG2N=3; 8 good samples 100..107, out_ready=1 -> one clk after the 8th listo: out_valid=1, out_avg=103 (828>>3), out_max=107; valid drops the cycle after acceptance; cnt returns to 0.
- LOG2N=3; 8 samples of 4095 -> out_avg=4095, out_max=4095; then 8 samples of 0 -> out_avg=0, out_max=0 (max restarts per window).
- Third frame sent with zeros=4'b0001, dato=4000; then 8 good samples of 10 -> frame_err=1; 4000 excluded; out_avg=10, out_max=10; result appears after 9 total strobes.
- out_ready=0; two full windows (avg 50, then avg 60) -> first result held at out_avg=50; overrun=1 after the second window completes; then out_ready=1 for one cycle -> out_valid=0.
- Window completes in the same cycle out_ready accepts a held result -> new result loaded; out_valid stays 1; overrun stays 0.
- rst pulse after 5 of 8 samples, then clr asserted together with a listo -> all outputs 0; the strobe coinciding with clr is not counted; the next 8 good samples produce a correct average.
